prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning program address width.
REQ-002 The block SHALL have parameter INSTR_W, default 8, meaning program word width (even, >= 4).
REQ-003 The block SHALL have parameter STACK_DEPTH, default 4, meaning return-stack entries (>= 1).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have these ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- mem_req  out  1  program fetch request
- mem_addr  out  ADDR_W  fetch address, equals pc
- mem_ack  in  1  fetch data valid this cycle
- mem_data  in  INSTR_W  fetched word
- instr  out  INSTR_W/2  upper half of latched word
- operand  out  INSTR_W/2  lower half of latched word
- phase  out  1  high in EXEC
- pc  out  ADDR_W  program counter
- inc_pc  in  1  EXEC: skip one extra word
- load_pc  in  1  EXEC: jump
- call  in  1  EXEC: push return address and jump
- ret  in  1  EXEC: pop into pc
- jump_target  in  ADDR_W  jump/call destination
- stack_ovf  out  1  sticky overflow flag
- stack_unf  out  1  sticky underflow flag

Function
REQ-006 The FSM SHALL have states FETCH and EXEC; phase SHALL be 1 only in EXEC.
REQ-007 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc. The FSM SHALL hold in FETCH with pc unchanged for any number of cycles while mem_ack is 0.
REQ-008 On a FETCH cycle with mem_ack=1, the block SHALL:
- latch mem_data into {instr, operand};
- set pc to pc+1;
- enter EXEC on the next cycle.
REQ-009 EXEC SHALL last exactly one cycle, then the FSM SHALL return to FETCH. Minimum fetch-to-fetch latency is 2 cycles.
REQ-010 In EXEC, control inputs SHALL apply with priority ret > call > load_pc > inc_pc. Lower-priority inputs asserted in the same cycle SHALL be ignored.
- ret: pc <= top of stack; pop.
- call: push pc (already incremented); pc <= jump_target.
- load_pc: pc <= jump_target.
- inc_pc: pc <= pc+1.
- none: pc unchanged.
REQ-011 Control inputs asserted in FETCH SHALL have no effect.
REQ-012 All pc arithmetic SHALL be modulo 2^ADDR_W, so pc wraps from all-ones to 0.
REQ-013 A call with STACK_DEPTH entries already held SHALL set stack_ovf, discard the push, and still take the jump.
REQ-014 A ret with an empty stack SHALL set stack_unf and leave pc unchanged.
REQ-015 stack_ovf and stack_unf SHALL clear only on reset.
REQ-016 instr and operand SHALL hold their value until the next mem_ack.

Reset
REQ-017 Reset SHALL asynchronously set the following, and SHALL abort any pending fetch:
- state = FETCH, pc = 0;
- instr = 0, operand = 0;
- stack empty;
- stack_ovf = 0, stack_unf = 0.
REQ-018 After reset deasserts, mem_req SHALL be 1 with mem_addr = 0 on the first clock edge.

Structure
REQ-019 The state enum and the STACK_DEPTH-derived pointer width SHALL live in the shared package seq_pkg.
REQ-020 The return stack SHALL be a separate sub-module ret_stack, with push, pop, full, empty and top ports, and the same clock and reset.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then mem_ack=1 with mem_data=0xA5 on the first cycle -> next cycle phase=1, instr=0xA, operand=0x5, pc=1.
- mem_ack held 0 for 3 cycles -> mem_req=1, pc constant, phase=0 throughout; the ack on cycle 4 latches the word.
- At pc=0x010, call with jump_target=0x200, then ret two fetches later -> pc=0x200, then pc=0x011.
- STACK_DEPTH=4: five nested calls -> stack_ovf=1 after the fifth; five rets -> four restore correctly, and the fifth sets stack_unf with pc unchanged.
- pc=0xFFF, fetch acked -> pc=0x000; inc_pc in EXEC -> pc=0x001.
- ret and call asserted together in EXEC -> ret taken, no push. Reset asserted during a FETCH wait -> mem_req stays 1, pc=0, flags clear.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared FSM state type and return-stack sizing helpers
package seq_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int ptr_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address LIFO; pushes when full and pops when empty are dropped
module ret_stack
  import seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = idx_w(DEPTH);

  logic [PW-1:0] r_count;
  logic [W-1:0]  r_mem [2**AW];
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_top_idx;

  assign full      = (r_count == PW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop     = pop && !empty;
  assign w_push    = push && !full && !pop;
  assign w_top_idx = AW'(r_count - PW'(1));
  assign top       = empty ? '0 : r_mem[w_top_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_pop) begin
      r_count <= r_count - PW'(1);
    end else if (w_push) begin
      r_count <= r_count + PW'(1);
    end
  end

  // Entries above the count are dead, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_count[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - two-phase fetch/execute program sequencer with call/return stack
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int INSTR_W     = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_ack,
  input  logic [INSTR_W-1:0]   mem_data,
  output logic [INSTR_W/2-1:0] instr,
  output logic [INSTR_W/2-1:0] operand,
  output logic                 phase,
  output logic [ADDR_W-1:0]    pc,
  input  logic                 inc_pc,
  input  logic                 load_pc,
  input  logic                 call,
  input  logic                 ret,
  input  logic [ADDR_W-1:0]    jump_target,
  output logic                 stack_ovf,
  output logic                 stack_unf
);

  localparam int HW = INSTR_W / 2;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [HW-1:0]       r_instr;
  logic [HW-1:0]       r_operand;
  logic                r_ovf;
  logic                r_unf;
  logic                w_exec;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [ADDR_W-1:0]   w_top;

  assign w_exec    = (r_state == EXEC);
  assign w_pop     = w_exec && ret;
  assign w_push    = w_exec && call && !ret;

  assign mem_req   = (r_state == FETCH);
  assign mem_addr  = r_pc;
  assign pc        = r_pc;
  assign phase     = w_exec;
  assign instr     = r_instr;
  assign operand   = r_operand;
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_pc),
    .top   (w_top),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_pc      <= '0;
      r_instr   <= '0;
      r_operand <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (mem_ack) begin
            r_instr   <= mem_data[INSTR_W-1:HW];
            r_operand <= mem_data[HW-1:0];
            r_pc      <= r_pc + ADDR_W'(1);
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          r_state <= FETCH;
          // pc already points past the executing word, so it is the return address.
          if (ret) begin
            if (w_empty) r_unf <= 1'b1;
            else         r_pc  <= w_top;
          end else if (call) begin
            if (w_full) r_ovf <= 1'b1;
            r_pc <= jump_target;
          end else if (load_pc) begin
            r_pc <= jump_target;
          end else if (inc_pc) begin
            r_pc <= r_pc + ADDR_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - directed self-checking bench for prog_sequencer
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [3:0]  instr;
  logic [3:0]  operand;
  logic        phase;
  logic [11:0] pc;
  logic        inc_pc;
  logic        load_pc;
  logic        call;
  logic        ret;
  logic [11:0] jump_target;
  logic        stack_ovf;
  logic        stack_unf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prog_sequencer #(
    .ADDR_W      (12),
    .INSTR_W     (8),
    .STACK_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .instr       (instr),
    .operand     (operand),
    .phase       (phase),
    .pc          (pc),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .call        (call),
    .ret         (ret),
    .jump_target (jump_target),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Starts on a negedge in FETCH: acks one word, applies the controls in EXEC,
  // and returns on the negedge after EXEC (back in FETCH).
  task automatic step(input logic [7:0] data, input logic r, input logic c,
                      input logic l, input logic i, input logic [11:0] tgt);
    mem_ack  = 1'b1;
    mem_data = data;
    @(negedge clk);
    mem_ack     = 1'b0;
    ret         = r;
    call        = c;
    load_pc     = l;
    inc_pc      = i;
    jump_target = tgt;
    @(negedge clk);
    ret     = 1'b0;
    call    = 1'b0;
    load_pc = 1'b0;
    inc_pc  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_data = '0;
    inc_pc = 1'b0; load_pc = 1'b0; call = 1'b0; ret = 1'b0; jump_target = '0;
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 1);
    check("rst_pc", pc, 0);
    check("rst_phase", phase, 0);
    check("rst_instr", {instr, operand}, 0);
    check("rst_flags", {stack_ovf, stack_unf}, 0);
    reset = 1'b0;

    // First-cycle fetch of 0xA5
    check("first_addr", mem_addr, 0);
    mem_ack = 1'b1; mem_data = 8'hA5;
    @(negedge clk);
    mem_ack = 1'b0;
    check("a5_phase", phase, 1);
    check("a5_instr", instr, 4'hA);
    check("a5_operand", operand, 4'h5);
    check("a5_pc", pc, 12'h001);
    @(negedge clk);
    check("a5_back_fetch", phase, 0);

    // Three-cycle wait with controls asserted in FETCH that must be ignored
    load_pc = 1'b1; call = 1'b1; jump_target = 12'h123;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wait_req", mem_req, 1);
      check("wait_pc", pc, 12'h001);
      check("wait_phase", phase, 0);
    end
    load_pc = 1'b0; call = 1'b0;
    mem_ack = 1'b1; mem_data = 8'h3C;
    @(negedge clk);
    mem_ack = 1'b0;
    check("wait_latch", {instr, operand}, 8'h3C);
    check("wait_pc2", pc, 12'h002);
    check("a5_held_phase", phase, 1);
    load_pc = 1'b1; jump_target = 12'h010;
    @(negedge clk);
    load_pc = 1'b0;
    check("load_pc", pc, 12'h010);

    // Call from 0x010 to 0x200, return two fetches later
    step(8'h11, 0, 1, 0, 0, 12'h200);
    check("call_pc", pc, 12'h200);
    check("hold_instr", {instr, operand}, 8'h11);
    step(8'h22, 0, 0, 0, 0, 12'h000);
    check("none_pc", pc, 12'h201);
    step(8'h33, 1, 0, 0, 0, 12'h000);
    check("ret_pc", pc, 12'h011);

    // Five nested calls: fifth overflows
    step(8'h00, 0, 1, 0, 0, 12'h300);
    step(8'h00, 0, 1, 0, 0, 12'h310);
    step(8'h00, 0, 1, 0, 0, 12'h320);
    step(8'h00, 0, 1, 0, 0, 12'h330);
    check("ovf_after4", stack_ovf, 0);
    step(8'h00, 0, 1, 0, 0, 12'h340);
    check("ovf_after5", stack_ovf, 1);
    check("ovf_jump", pc, 12'h340);
    step(8'h00, 1, 0, 0, 0, 12'h000);
    check("ret1", pc, 12'h321);
    step(8'h00, 1, 0, 0, 0, 12'h000);
    check("ret2", pc, 12'h311);
    step(8'h00, 1, 0, 0, 0, 12'h000);
    check("ret3", pc, 12'h301);
    step(8'h00, 1, 0, 0, 0, 12'h000);
    check("ret4", pc, 12'h012);
    check("unf_before5", stack_unf, 0);
    step(8'h00, 1, 0, 0, 0, 12'h000);
    check("unf_after5", stack_unf, 1);
    check("unf_pc", pc, 12'h013);

    // ret beats call; no push happens
    step(8'h00, 0, 1, 0, 0, 12'h500);
    check("call2_pc", pc, 12'h500);
    step(8'h00, 1, 1, 1, 1, 12'h600);
    check("ret_over_call", pc, 12'h014);
    step(8'h00, 1, 0, 0, 0, 12'h000);
    check("no_push", pc, 12'h015);
    step(8'h00, 0, 0, 1, 1, 12'h0FF);
    check("load_over_inc", pc, 12'h0FF);

    // pc wrap
    step(8'h00, 0, 0, 1, 0, 12'hFFF);
    check("at_fff", pc, 12'hFFF);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("wrap_pc", pc, 12'h000);
    inc_pc = 1'b1;
    @(negedge clk);
    inc_pc = 1'b0;
    check("wrap_inc", pc, 12'h001);

    // Asynchronous reset during a FETCH wait
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_req", mem_req, 1);
    check("arst_pc", pc, 0);
    check("arst_flags", {stack_ovf, stack_unf}, 0);
    check("arst_instr", {instr, operand}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req", mem_req, 1);
    check("post_rst_addr", mem_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
